// File: rtl/irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// irq_priority_encoder
//
// Collects N_REQ request lines into a sticky pending register, filters them
// with a per-line mask and presents the winning line index on a valid/ack
// handshake. The index feeds the control unit as a vector/opcode select.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_in       request lines; a 1 on bit i sets pending[i] at the next edge
//   mask         per-line grant enable (1 = eligible)
//   out_ack      consumer accepts the presented code
//   out_valid    out_code holds a valid winning index
//   out_code     encoded index of the granted line
//   pending      current pending register (unmasked)
//   any_pending  OR-reduction of (pending & mask)
//
// Build option:
//   IRQ_PRIORITY_ROUND_ROBIN_EN  when defined, arbitration is round-robin:
//   the search starts one above the last acknowledged code and wraps. When
//   undefined, the highest eligible index always wins.
//
// N_REQ must equal 2**CODE_W so that index arithmetic wraps naturally.
// ---------------------------------------------------------------------------
module irq_priority_encoder #(
    parameter int CODE_W = 4,
    parameter int N_REQ  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_in,
    input  logic [N_REQ-1:0]  mask,
    input  logic              out_ack,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    output logic [N_REQ-1:0]  pending,
    output logic              any_pending
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [N_REQ-1:0]    pending_reg, pending_next;
    logic [CODE_W-1:0]   code_reg, code_next;
    logic [N_REQ-1:0]    clr;
    logic [N_REQ-1:0]    eligible;
    logic [CODE_W-1:0]   winner;
    logic                grant_taken;

    assign eligible    = pending_reg & mask;
    // An ack only counts while a code is actually being presented.
    assign grant_taken = (state_reg == PRESENT) && out_ack;

    // One-hot clear of the acknowledged line.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_clr
            assign clr[gi] = grant_taken && (code_reg == CODE_W'(gi));
        end
    endgenerate

`ifdef IRQ_PRIORITY_ROUND_ROBIN_EN
    logic [CODE_W-1:0] last_grant_reg;
    logic [CODE_W-1:0] search_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= '0;
        end else if (grant_taken) begin
            last_grant_reg <= code_reg;
        end
    end

    // Walk offsets from N_REQ down to 1 so the smallest offset (the line just
    // above last_grant) is assigned last and therefore takes precedence.
    // Offset N_REQ wraps to last_grant itself, which has the lowest priority.
    always_comb begin
        winner     = '0;
        search_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            search_idx = last_grant_reg + CODE_W'(k);
            if (eligible[search_idx]) begin
                winner = search_idx;
            end
        end
    end
`else
    // Ascending scan: the highest eligible index is assigned last and wins.
    always_comb begin
        winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (eligible[i]) begin
                winner = CODE_W'(i);
            end
        end
    end
`endif

    // Set has precedence over clear, so a fresh request in the ack cycle
    // of the same line is kept.
    assign pending_next = (pending_reg & ~clr) | req_in;

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        case (state_reg)
            IDLE: begin
                if (|eligible) begin
                    code_next  = winner;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                // code_reg is frozen here regardless of mask/pending changes.
                if (out_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            code_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            code_reg    <= code_next;
        end
    end

    assign out_valid   = (state_reg == PRESENT);
    assign out_code    = code_reg;
    assign pending     = pending_reg;
    assign any_pending = |eligible;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_irq_priority_encoder
//
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level behavioural model (integer pending set, presenting flag,
// granted code and, for round-robin builds, the last acknowledged line).
// ---------------------------------------------------------------------------
module tb_irq_priority_encoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_in;
    logic [15:0] mask;
    logic        out_ack;
    logic        out_valid;
    logic [3:0]  out_code;
    logic [15:0] pending;
    logic        any_pending;

    irq_priority_encoder #(.CODE_W(4), .N_REQ(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .mask        (mask),
        .out_ack     (out_ack),
        .out_valid   (out_valid),
        .out_code    (out_code),
        .pending     (pending),
        .any_pending (any_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [15:0] m_pend;
    bit          m_valid;
    int          m_code;
    int          m_last;
    int          grants[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [15:0] elig);
`ifdef IRQ_PRIORITY_ROUND_ROBIN_EN
        for (int k = 1; k <= 16; k++) begin
            int idx;
            idx = (m_last + k) % 16;
            if (elig[idx]) return idx;
        end
`else
        for (int i = 15; i >= 0; i--) begin
            if (elig[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 0;
        m_code  = 0;
        m_last  = 0;
    endtask

    // One clock edge of the model, using the inputs applied during the cycle.
    task automatic model_step();
        logic [15:0] clr;
        clr = '0;
        if (m_valid && out_ack) clr = 16'h1 << m_code;
        if (!m_valid) begin
            if ((m_pend & mask) != 0) begin
                m_code  = model_winner(m_pend & mask);
                m_valid = 1;
            end
        end else if (out_ack) begin
            m_valid = 0;
            m_last  = m_code;
            grants.push_back(m_code);
            $display("grant accepted: code %0d at %0t", m_code, $time);
        end
        m_pend = (m_pend & ~clr) | req_in;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_valid"},   32'(out_valid),   32'(m_valid));
        check_eq({tag, "_code"},    32'(out_code),    32'(m_code));
        check_eq({tag, "_pending"}, 32'(pending),     32'(m_pend));
        check_eq({tag, "_any"},     32'(any_pending), 32'(((m_pend & mask) != 0)));
    endtask

    // Called at posedge+1: apply inputs, compare on the falling edge,
    // advance the model on the rising edge, return at posedge+1.
    task automatic cycle(input logic [15:0] r, input logic [15:0] m, input logic a, input string tag);
        req_in  = r;
        mask    = m;
        out_ack = a;
        @(negedge clk);
        check_model(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req_in  = '0;
        mask    = '0;
        out_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int exp_order[3];
    int exp_mask_code;

    initial begin
        do_reset();

        // Quiet after reset
        for (int i = 0; i < 10; i++) cycle(16'h0000, 16'hFFFF, 1'b0, "idle");
        check_eq("idle_code0", 32'(out_code), 32'h0);

        // Single pulse on line 5
        cycle(16'h0020, 16'hFFFF, 1'b0, "p5");
        check_eq("p5_pend_n1",  32'(pending),   32'h0020);
        check_eq("p5_valid_n1", 32'(out_valid), 32'h0);
        cycle(16'h0000, 16'hFFFF, 1'b0, "p5");
        check_eq("p5_valid_n2", 32'(out_valid), 32'h1);
        check_eq("p5_code",     32'(out_code),  32'h5);
        cycle(16'h0000, 16'hFFFF, 1'b0, "p5");
        check_eq("p5_hold",     32'(out_valid), 32'h1);
        cycle(16'h0000, 16'hFFFF, 1'b1, "p5");
        check_eq("p5_after_ack_valid", 32'(out_valid), 32'h0);
        check_eq("p5_after_ack_pend",  32'(pending),   32'h0);

        // Three lines, immediate ack; 6 cycles must yield exactly 3 grants
        do_reset();
        grants.delete();
        cycle(16'h8101, 16'hFFFF, 1'b0, "multi");
        for (int i = 0; i < 6; i++) cycle(16'h0000, 16'hFFFF, m_valid, "multi");
`ifdef IRQ_PRIORITY_ROUND_ROBIN_EN
        exp_order = '{8, 15, 0};
`else
        exp_order = '{15, 8, 0};
`endif
        check_eq("multi_count", 32'(grants.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < grants.size()) check_eq($sformatf("multi_order%0d", i), 32'(grants[i]), 32'(exp_order[i]));
        end
        check_eq("multi_pend_end", 32'(pending), 32'h0);

        // Masked requests stay pending until the mask opens
        cycle(16'h0F00, 16'h00FF, 1'b0, "mask");
        for (int i = 0; i < 3; i++) cycle(16'h0000, 16'h00FF, 1'b0, "mask");
        check_eq("mask_valid", 32'(out_valid), 32'h0);
        check_eq("mask_pend",  32'(pending),   32'h0F00);
        cycle(16'h0000, 16'hFFFF, 1'b0, "mask");
        cycle(16'h0000, 16'hFFFF, 1'b0, "mask");
`ifdef IRQ_PRIORITY_ROUND_ROBIN_EN
        exp_mask_code = 8;
`else
        exp_mask_code = 11;
`endif
        check_eq("mask_open_valid", 32'(out_valid), 32'h1);
        check_eq("mask_open_code",  32'(out_code),  32'(exp_mask_code));
        for (int i = 0; i < 10; i++) cycle(16'h0000, 16'hFFFF, m_valid, "drain");
        check_eq("drain_pend", 32'(pending), 32'h0);

        // Re-request of line 3 during its own ack cycle
        do_reset();
        cycle(16'h0008, 16'hFFFF, 1'b0, "set_wins");
        cycle(16'h0000, 16'hFFFF, 1'b0, "set_wins");
        check_eq("sw_code", 32'(out_code), 32'h3);
        cycle(16'h0008, 16'hFFFF, 1'b1, "set_wins");
        check_eq("sw_bubble", 32'(out_valid), 32'h0);
        check_eq("sw_pend",   32'(pending),   32'h0008);
        cycle(16'h0000, 16'hFFFF, 1'b0, "set_wins");
        check_eq("sw_regrant_valid", 32'(out_valid), 32'h1);
        check_eq("sw_regrant_code",  32'(out_code),  32'h3);

        // Asynchronous reset while presenting
        req_in = 16'h00F0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'h0);
        check_eq("arst_pend",  32'(pending),   32'h0);
        check_eq("arst_code",  32'(out_code),  32'h0);
        model_reset();
        req_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] r;
            logic [15:0] m;
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            m = 16'($urandom) | 16'($urandom);
            cycle(r, m, 1'($urandom_range(0, 1)), "rand");
        end
        for (int i = 0; i < 40; i++) cycle(16'h0000, 16'hFFFF, m_valid, "flush");
        check_eq("flush_pend", 32'(pending), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_priority_encoder.md
Name: irq_priority_encoder

Overview:
- Inverse of the control-line decoder: collects up to 16 one-hot request lines and encodes the winning line to a 4-bit index.
- Requests are latched into a pending register, filtered by a mask, and the winner is presented on a valid/ack handshake.
- Sits between peripheral/interrupt sources and the 8-bit control unit, which consumes the index as a vector/opcode select.

Parameters:
- CODE_W, 4, width of the encoded index output.
- N_REQ, 16, number of request lines; must equal 2**CODE_W.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  N_REQ  request lines; a 1 on bit i in any cycle sets pending[i].
- mask  input  N_REQ  enable per line; 1 = line eligible for grant.
- out_ack  input  1  consumer accepts the presented code.
- out_valid  output  1  out_code holds a valid winning index.
- out_code  output  CODE_W  encoded index of the granted line.
- pending  output  N_REQ  current pending register (unmasked).
- any_pending  output  1  OR-reduction of (pending & mask), combinational from registers.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: pending=0, out_valid=0, out_code=0, FSM=IDLE; takes effect immediately on rst_n low, regardless of state.
- Pending update each cycle: pending <= (pending & ~clr) | req_in, where clr is the one-hot of out_code when out_valid && out_ack, else 0.
- Same-cycle set and clear of the same bit: set wins, so the new request is kept.
- Two-state FSM:
  - IDLE: out_valid=0. If (pending & mask) != 0, register the winning index into out_code and go to PRESENT.
  - PRESENT: out_valid=1 and out_code held stable. On out_ack=1, clear that pending bit and go to IDLE. Otherwise stay.
- Priority (default): fixed, highest index wins (bit 15 over bit 0).
- Latency:
  - req_in high at cycle N sets pending at the N+1 edge.
  - out_valid rises at the N+2 edge.
  - After ack at cycle M, out_valid is low for cycle M+1. Next grant at earliest M+2.
  - Maximum throughput is one grant per 2 cycles.
- Mask or pending changes during PRESENT do not alter out_code. A granted code is always completed even if its mask bit drops.
- out_ack while out_valid=0 is ignored.
- All req_in bits zero and nothing pending: remain in IDLE, out_code keeps its last value.
- Reset mid-PRESENT: grant is abandoned, all pending cleared.

Optional Feature:
- Macro: IRQ_PRIORITY_ROUND_ROBIN_EN.
- Defined:
  - A CODE_W-bit last_grant register (reset 0) is loaded with out_code on each ack.
  - Search starts at last_grant+1, ascending with wrap-around modulo N_REQ. The first eligible line wins.
- Undefined: fixed highest-index priority as above, and no last_grant register exists.

Test Plan:
- Reset then req_in=16'h0000 for 10 cycles -> out_valid=0, pending=0, out_code=0 throughout.
- mask=16'hFFFF, pulse req_in=16'h0020 for one cycle at N -> pending=16'h0020 at N+1. out_valid=1, out_code=5 at N+2. Holds until ack. Pending clears the cycle after ack.
- mask=16'hFFFF, pulse req_in=16'h8101, ack each grant immediately -> codes 15, 8, 0 in that order, spaced 2 cycles apart. Pending ends at 0. Under IRQ_PRIORITY_ROUND_ROBIN_EN from last_grant=0: order 8, 15, 0.
- mask=16'h00FF, req_in=16'h0F00 -> out_valid stays 0, pending=16'h0F00. Then set mask=16'hFFFF -> out_code=11 two cycles later.
- While presenting code 3, assert req_in=16'h0008 in the ack cycle -> bit 3 stays pending, and code 3 is presented again after the IDLE bubble.
- Drive rst_n low asynchronously mid-PRESENT (between clock edges) -> out_valid=0 and pending=0 immediately, without waiting for a clock edge.
